// File: rtl/deadlock_report_unit.sv
// Confirms a persistent deadlock indication from the dataflow monitor and offers
// one timestamped stop snapshot per deadlock episode over a valid/ready handshake.
module deadlock_report_unit #(
  parameter int unsigned NUM_PROC       = 4,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned TS_W           = 32,
  parameter int unsigned EVT_W          = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                block_i,
  input  logic [NUM_PROC-1:0] proc_stop_vec_i,
  input  logic                clear_i,
  output logic                report_valid_o,
  input  logic                report_ready_i,
  output logic [NUM_PROC-1:0] report_proc_vec_o,
  output logic [TS_W-1:0]     report_ts_o,
  output logic                deadlock_o,
  output logic [EVT_W-1:0]    event_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    REPORT  = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [16:0] CONFIRM_LAST = 17'(CONFIRM_CYCLES);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [TS_W-1:0]     ts_q;
  logic                valid_q, valid_d;
  logic [NUM_PROC-1:0] vec_q, vec_d;
  logic [TS_W-1:0]     rts_q, rts_d;
  logic                dl_q, dl_d;
  logic [EVT_W-1:0]    ev_q, ev_d;
  logic                confirm_done;
  logic                enter_report;

  assign confirm_done = ({1'b0, cnt_q} + 17'd1) == CONFIRM_LAST;
  assign enter_report = (state_d == REPORT) && (state_q != REPORT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear overrides every transition, including completion of a handshake.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (block_i) begin
            state_d = (CONFIRM_CYCLES == 1) ? REPORT : CONFIRM;
          end
        end
        CONFIRM: begin
          if (!block_i) begin
            state_d = IDLE;
          end else if (confirm_done) begin
            state_d = REPORT;
          end
        end
        REPORT: begin
          if (report_ready_i) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!block_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = (state_d == REPORT);
    vec_d   = vec_q;
    rts_d   = rts_q;
    dl_d    = dl_q;
    ev_d    = ev_q;
    if (clear_i) begin
      cnt_d = '0;
      dl_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    cnt_d = block_i ? 16'd1 : '0;
        CONFIRM: cnt_d = (block_i && !confirm_done) ? cnt_q + 16'd1 : '0;
        default: cnt_d = '0;
      endcase
      // Snapshot taken on the entry edge so the payload is frozen for the whole offer.
      if (enter_report) begin
        vec_d = proc_stop_vec_i;
        rts_d = ts_q;
        dl_d  = 1'b1;
        if (ev_q != '1) begin
          ev_d = ev_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ts_q    <= '0;
      valid_q <= 1'b0;
      vec_q   <= '0;
      rts_q   <= '0;
      dl_q    <= 1'b0;
      ev_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ts_q    <= ts_q + 1'b1;
      valid_q <= valid_d;
      vec_q   <= vec_d;
      rts_q   <= rts_d;
      dl_q    <= dl_d;
      ev_q    <= ev_d;
    end
  end

  assign report_valid_o    = valid_q;
  assign report_proc_vec_o = vec_q;
  assign report_ts_o       = rts_q;
  assign deadlock_o        = dl_q;
  assign event_count_o     = ev_q;

endmodule

// File: tb/tb_deadlock_report_unit.sv
// Randomized and directed checks of deadlock_report_unit against an episode-level model.
module tb_deadlock_report_unit;

  localparam int unsigned NP = 4;
  localparam int unsigned CC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          block;
  logic [NP-1:0] vec;
  logic          clear;
  logic          ready;
  logic          valid;
  logic [NP-1:0] rvec;
  logic [31:0]   rts;
  logic          dl;
  logic [7:0]    ev;

  deadlock_report_unit #(
    .NUM_PROC      (NP),
    .CONFIRM_CYCLES(CC),
    .TS_W          (32),
    .EVT_W         (8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .block_i          (block),
    .proc_stop_vec_i  (vec),
    .clear_i          (clear),
    .report_valid_o   (valid),
    .report_ready_i   (ready),
    .report_proc_vec_o(rvec),
    .report_ts_o      (rts),
    .deadlock_o       (dl),
    .event_count_o    (ev)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a report is offered after CC consecutive high samples of block
  // outside an offer; after acceptance, block must fall before a new episode starts.
  logic          m_valid, m_hold, m_dl;
  int            m_run, m_ev;
  logic [NP-1:0] m_vec;
  logic [31:0]   m_ts, m_tscap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_hold = 1'b0; m_dl = 1'b0;
    m_run = 0; m_ev = 0; m_vec = '0; m_ts = '0; m_tscap = '0;
  endtask

  task automatic model_edge();
    if (clear) begin
      m_dl = 1'b0; m_run = 0; m_valid = 1'b0; m_hold = 1'b0;
    end else if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_hold  = 1'b1;
      end
    end else if (m_hold) begin
      if (!block) m_hold = 1'b0;
    end else if (block) begin
      m_run++;
      if (m_run == CC) begin
        m_valid = 1'b1;
        m_vec   = vec;
        m_tscap = m_ts;
        m_dl    = 1'b1;
        if (m_ev < 255) m_ev++;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_ts = m_ts + 32'd1;
  endtask

  task automatic check_all();
    check("valid", 64'(valid), 64'(m_valid));
    check("proc_vec", 64'(rvec), 64'(m_vec));
    check("ts", 64'(rts), 64'(m_tscap));
    check("deadlock", 64'(dl), 64'(m_dl));
    check("event_count", 64'(ev), 64'(m_ev));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ev_before;
    rst = 1'b1; block = 1'b0; vec = '0; clear = 1'b0; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_deadlock", 64'(dl), 64'd0);
    check("rst_event_count", 64'(ev), 64'd0);
    check("rst_ts", 64'(rts), 64'd0);
    rst = 1'b0;

    // First report timed from timestamp 100
    while (m_ts != 32'd100) step();
    block = 1'b1; vec = 4'b1011;
    repeat (4) step();
    check("first_valid", 64'(valid), 64'd1);
    check("first_ts", 64'(rts), 64'd103);
    check("first_vec", 64'(rvec), 64'hb);
    check("first_ev", 64'(ev), 64'd1);

    // Backpressure with input churn, then accept, then no re-report while blocked
    for (int i = 0; i < 10; i++) begin
      block = 1'(i % 2); vec = 4'($urandom);
      step();
    end
    check("stall_ts", 64'(rts), 64'd103);
    check("stall_vec", 64'(rvec), 64'hb);
    block = 1'b1; ready = 1'b1; step();
    ready = 1'b0;
    repeat (8) step();
    check("hold_no_rereport", 64'(ev), 64'd1);
    block = 1'b0; step();
    block = 1'b1; repeat (4) step();
    check("second_report_ev", 64'(ev), 64'd2);
    check("second_report_valid", 64'(valid), 64'd1);

    // Clear during an unaccepted offer
    clear = 1'b1; step();
    clear = 1'b0;
    check("clear_valid", 64'(valid), 64'd0);
    check("clear_deadlock", 64'(dl), 64'd0);
    check("clear_ev_kept", 64'(ev), 64'd2);
    block = 1'b0; repeat (2) step();

    // Interrupted burst restarts the confirm window
    ev_before = m_ev;
    block = 1'b1; repeat (3) step();
    block = 1'b0; step();
    block = 1'b1; repeat (3) step();
    check("burst_not_yet", 64'(valid), 64'd0);
    step();
    check("burst_report", 64'(valid), 64'd1);
    check("burst_ev", 64'(ev), 64'(ev_before + 1));
    ready = 1'b1; step();
    block = 1'b0; ready = 1'b0; step();

    for (int i = 0; i < 800; i++) begin
      block = ($urandom_range(0, 9) < 8);
      ready = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 49) == 0);
      vec   = 4'($urandom);
      step();
    end
    clear = 1'b1; block = 1'b0; ready = 1'b0; step();
    clear = 1'b0;

    // Saturation of the event counter
    ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      block = 1'b1; vec = 4'($urandom);
      repeat (5) step();
      block = 1'b0; step();
    end
    check("ev_saturated", 64'(ev), 64'd255);
    ready = 1'b0;

    // Asynchronous reset in the middle of an offer
    block = 1'b1; repeat (4) step();
    check("pre_reset_valid", 64'(valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", 64'(valid), 64'd0);
    check("async_vec", 64'(rvec), 64'd0);
    check("async_ts", 64'(rts), 64'd0);
    check("async_deadlock", 64'(dl), 64'd0);
    check("async_ev", 64'(ev), 64'd0);
    model_reset();
    #2 rst = 1'b0;
    repeat (3) step();
    check("post_reset_no_early", 64'(valid), 64'd0);
    step();
    check("post_reset_report", 64'(valid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
